rtc_disp_scan: RTL
==================

Name: rtc_disp_scan

Overview:
Time-multiplexed scan controller for the Nexys A7 eight-digit common-anode 7-segment display. Takes the six per-digit segment codes produced by the BCD-to-segment decoder and drives one shared cathode bus plus the anode selects. It sequences digits 1..6, inserts an anti-ghosting blank at each digit change, and freezes a per-frame snapshot of its inputs so a digit never changes part-way through a scan. It sits between the stopwatch/RTC segment decoder and the board pins.

Parameters:
SLOT_CYCLES, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be >= 2.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; 1 <= BLANK_CYCLES < SLOT_CYCLES.

Ports:
i_clk  input  1  system clock; all logic on the rising edge.
i_rst_n  input  1  synchronous, active-low reset.
i_enable  input  1  scan enable; low forces the display dark and restarts the frame.
i_segout1..i_segout6  input  8 each  active-low segment codes; digit 1 is the rightmost digit, on anode 0.
i_digit_en  input  6  per-digit enable; bit k-1 gates digit k.
o_an  output  8  active-low anode selects; bits 7:6 are always 1.
o_seg  output  8  active-low cathodes {dp,g..a}.
o_frame_done  output  1  one-cycle pulse at the end of each 6-digit frame.

Behaviour:
- One clock domain. Reset is synchronous and active-low.
- Reset values:
  - idx = 0, cnt = 0.
  - o_an = 8'hFF, o_seg = 8'hFF, o_frame_done = 0.
  - Snapshot registers: segment codes = 8'hFF, i_digit_en = 0.
- Counters:
  - cnt runs 0..SLOT_CYCLES-1, then wraps to 0 and increments idx.
  - idx runs 0..5, then wraps to 0.
- Phases within a slot:
  - BLANK phase is cnt < BLANK_CYCLES.
  - DRIVE phase is the remainder of the slot.
- Snapshot: loaded from i_segout1..6 and i_digit_en on every edge where idx==0 and cnt==0. It therefore reloads exactly once per frame, and on the first enabled cycle after reset.
- Outputs are registered and computed from the next-state idx/cnt, so they align with the current idx/cnt each cycle.
- In BLANK: o_an = 8'hFF, o_seg = 8'hFF.
- In DRIVE:
  - If snap_en[idx] = 1: o_an = ~(8'b1 << idx), o_seg = snap_seg[idx].
  - If snap_en[idx] = 0: o_an = 8'hFF, o_seg = 8'hFF.
- o_frame_done = 1 exactly in the cycle where idx==5 and cnt==SLOT_CYCLES-1.
- Frame period is 6*SLOT_CYCLES cycles.
- i_enable = 0:
  - Next state is idx = 0, cnt = 0; outputs are all-off and o_frame_done = 0.
  - The snapshot reloads each cycle.
  - Scanning resumes from digit 1 BLANK on the first cycle that i_enable is high.
- Input changes mid-frame: not visible until the next frame's snapshot.
- Reset mid-frame: returns to the reset values on the next edge, with no partial pulse on o_frame_done.
- Never more than one anode low at a time. Anodes 7:6 are never low.

Optional Feature:
RTC_SCAN_DIM_EN
- Defined:
  - Adds input i_dim (1 bit), captured into the snapshot with the other inputs.
  - When snap_dim = 1, a digit is driven only for cnt < BLANK_CYCLES + (SLOT_CYCLES-BLANK_CYCLES)/2 (floor division).
  - For the rest of the DRIVE phase, o_an = 8'hFF and o_seg = 8'hFF.
  - When snap_dim = 0, behaviour is identical to the undefined case.
- Undefined: the i_dim port does not exist and the full DRIVE phase is used.

Test Plan:
All tests use SLOT_CYCLES=8 and BLANK_CYCLES=2. Cycle 0 is the first cycle with i_rst_n high.
- Basic scan. Stimulus: reset, then i_enable=1, i_digit_en=6'h3F, segouts = C0, F9, A4, B0, 99, 92. Response:
  - During reset: o_an = FF, o_seg = FF.
  - Cycles 0-1: FF / FF.
  - Cycles 2-7: o_an = FE, o_seg = C0.
  - Cycles 10-15: o_an = FD, o_seg = F9.
  - Cycles 42-47: o_an = DF, o_seg = 92.
  - o_frame_done high only at cycles 47, 95, ...
- Snapshot. Stimulus: change i_segout1 to 'h80 at cycle 20. Response: digit 1 shows C0 through cycle 47; cycles 50-55 show 80.
- Digit enable. Stimulus: i_digit_en = 6'h3E. Response: cycles 0-7 stay FF / FF; digit 2 still drives at cycles 10-15.
- Enable drop. Stimulus: i_enable=0 at cycle 27 for 3 cycles, then back to 1. Response:
  - o_an = FF during the low cycles.
  - Digit 1 BLANK restarts on the first re-enabled cycle.
  - No o_frame_done until 47 cycles later.
- Reset mid-frame. Stimulus: i_rst_n=0 at cycle 30 for 2 cycles. Response: FF / FF during reset; after release, the scan restarts at digit 1 with identical timing to the basic scan.
- Dim (RTC_SCAN_DIM_EN defined). Stimulus: i_dim=1. Response: each slot drives only at cnt 2-4, e.g. digit 1 at cycles 2-4 with o_an = FE; cycles 5-7 are FF / FF.

Source files
------------

// File: rtl/rtc_disp_scan.sv
// rtc_disp_scan: six-digit time-multiplexed scan controller for the Nexys A7
// common-anode 7-segment display. Each digit owns a slot of SLOT_CYCLES clocks,
// the first BLANK_CYCLES of which keep every anode off to suppress ghosting.
// Segment codes and digit enables are frozen once per frame so a digit never
// changes part-way through a scan.
// Optional feature: define RTC_SCAN_DIM_EN to add the i_dim input, which halves
// the drive window of every slot.
module rtc_disp_scan #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic [7:0] i_segout1,
  input  logic [7:0] i_segout2,
  input  logic [7:0] i_segout3,
  input  logic [7:0] i_segout4,
  input  logic [7:0] i_segout5,
  input  logic [7:0] i_segout6,
  input  logic [5:0] i_digit_en,
`ifdef RTC_SCAN_DIM_EN
  input  logic       i_dim,
`endif
  output logic [7:0] o_an,
  output logic [7:0] o_seg,
  output logic       o_frame_done
);

  localparam int               CNT_W     = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [2:0]       IDX_LAST  = 3'd5;
`ifdef RTC_SCAN_DIM_EN
  // When dimmed, a digit is only lit up to the midpoint of its drive window.
  localparam logic [CNT_W-1:0] DIM_END   =
    CNT_W'(BLANK_CYCLES + (SLOT_CYCLES - BLANK_CYCLES) / 2);
`endif

  typedef enum logic [1:0] {
    PH_BLANK,
    PH_DRIVE,
    PH_DIMMED
  } phase_t;

  logic [2:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load;
  logic [5:0][7:0]  seg_in, snap_seg, seg_nxt;
  logic [5:0]       snap_en, en_nxt;
  phase_t           phase_nxt;
  logic [7:0]       an_nxt, seg_out_nxt;
  logic             done_nxt;
`ifdef RTC_SCAN_DIM_EN
  logic             snap_dim, dim_nxt;
`endif

  // Digit 1 sits in the low byte so idx directly selects the code and anode.
  assign seg_in = {i_segout6, i_segout5, i_segout4, i_segout3, i_segout2, i_segout1};

  // Next slot position and next snapshot; the snapshot reloads at the frame start.
  always_comb begin
    load    = (idx == 3'd0) && (cnt == '0);
    seg_nxt = load ? seg_in : snap_seg;
    en_nxt  = load ? i_digit_en : snap_en;
`ifdef RTC_SCAN_DIM_EN
    dim_nxt = load ? i_dim : snap_dim;
`endif
    idx_nxt = idx;
    cnt_nxt = cnt + CNT_ONE;
    if (!i_enable) begin
      idx_nxt = 3'd0;
      cnt_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end
  end

  // Output values for the next cycle, derived from the next position so the
  // registered outputs line up with the idx/cnt they describe.
  always_comb begin
    phase_nxt = PH_DRIVE;
    if (cnt_nxt < BLANK_END) begin
      phase_nxt = PH_BLANK;
    end
`ifdef RTC_SCAN_DIM_EN
    else if (dim_nxt && (cnt_nxt >= DIM_END)) begin
      phase_nxt = PH_DIMMED;
    end
`endif
    an_nxt      = 8'hFF;
    seg_out_nxt = 8'hFF;
    done_nxt    = 1'b0;
    if (i_enable) begin
      if ((phase_nxt == PH_DRIVE) && en_nxt[idx_nxt]) begin
        an_nxt      = ~(8'h01 << idx_nxt);
        seg_out_nxt = seg_nxt[idx_nxt];
      end
      done_nxt = (idx_nxt == IDX_LAST) && (cnt_nxt == CNT_LAST);
    end
  end

  // Counter, snapshot and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      idx          <= 3'd0;
      cnt          <= '0;
      snap_seg     <= {6{8'hFF}};
      snap_en      <= 6'd0;
      o_an         <= 8'hFF;
      o_seg        <= 8'hFF;
      o_frame_done <= 1'b0;
    end else begin
      idx          <= idx_nxt;
      cnt          <= cnt_nxt;
      snap_seg     <= seg_nxt;
      snap_en      <= en_nxt;
      o_an         <= an_nxt;
      o_seg        <= seg_out_nxt;
      o_frame_done <= done_nxt;
    end
  end

`ifdef RTC_SCAN_DIM_EN
  // Dim flag is frozen alongside the rest of the snapshot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      snap_dim <= 1'b0;
    end else begin
      snap_dim <= dim_nxt;
    end
  end
`endif

endmodule
